// File: rtl/cla_pkg.sv
// Shared width and word type for the 4-bit carry-lookahead adder slice.
package cla_pkg;
  localparam int CLA_WIDTH = 4;
  typedef logic [CLA_WIDTH-1:0] cla_word_t;
endpackage

// File: rtl/cla_core_4bit.sv
// Combinational 4-bit carry-lookahead core with flattened carry equations.
// Optional macro CLA_ADDER_OVF_EN adds the signed overflow output.
module cla_core_4bit
  import cla_pkg::*;
(
  input  cla_word_t a,
  input  cla_word_t b,
  input  logic      cin,
  output cla_word_t sum,
  output logic      cout,
  output logic      grp_p,
`ifdef CLA_ADDER_OVF_EN
  output logic      ovf,
`endif
  output logic      grp_g
);

  cla_word_t g;
  cla_word_t p;
  logic      c1, c2, c3, c4;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is a two-level sum of products over g/p/cin only; no carry feeds another.
  assign c1 = g[0] | (p[0] & cin);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign grp_p = &p;
  assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign c4    = grp_g | (grp_p & cin);

  assign sum  = p ^ {c3, c2, c1, cin};
  assign cout = c4;

`ifdef CLA_ADDER_OVF_EN
  assign ovf = c3 ^ c4;
`endif

endmodule

// File: rtl/cla_adder_4bit.sv
// 4-bit carry-lookahead adder with optional output register and valid qualifier.
// Optional macro CLA_ADDER_OVF_EN adds the registered ovf output.
module cla_adder_4bit
  import cla_pkg::*;
#(
  parameter int OUT_REG = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      in_valid,
  input  cla_word_t a,
  input  cla_word_t b,
  input  logic      cin,
  output logic      out_valid,
  output cla_word_t sum,
  output logic      cout,
  output logic      grp_p,
`ifdef CLA_ADDER_OVF_EN
  output logic      ovf,
`endif
  output logic      grp_g
);

  cla_word_t sum_c;
  logic      cout_c, grp_p_c, grp_g_c;
`ifdef CLA_ADDER_OVF_EN
  logic      ovf_c;
`endif

  cla_core_4bit u_core (
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum_c),
    .cout  (cout_c),
    .grp_p (grp_p_c),
`ifdef CLA_ADDER_OVF_EN
    .ovf   (ovf_c),
`endif
    .grp_g (grp_g_c)
  );

  generate
    if (OUT_REG != 0) begin : g_reg
      // Data only loads on a valid beat so idle cycles keep the last result visible.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          sum       <= '0;
          cout      <= 1'b0;
          grp_p     <= 1'b0;
          grp_g     <= 1'b0;
`ifdef CLA_ADDER_OVF_EN
          ovf       <= 1'b0;
`endif
        end else begin
          out_valid <= in_valid;
          if (in_valid) begin
            sum   <= sum_c;
            cout  <= cout_c;
            grp_p <= grp_p_c;
            grp_g <= grp_g_c;
`ifdef CLA_ADDER_OVF_EN
            ovf   <= ovf_c;
`endif
          end
        end
      end
    end else begin : g_comb
      // Reset still forces zeros even though nothing is stored.
      always_comb begin
        out_valid = in_valid & rst_n;
        sum       = rst_n ? sum_c : '0;
        cout      = cout_c & rst_n;
        grp_p     = grp_p_c & rst_n;
        grp_g     = grp_g_c & rst_n;
`ifdef CLA_ADDER_OVF_EN
        ovf       = ovf_c & rst_n;
`endif
      end
    end
  endgenerate

endmodule

// File: tb/tb_cla_adder_4bit.sv
// Self-checking bench for cla_adder_4bit (OUT_REG=1): arithmetic reference model,
// per-cycle compare, literal checks, random traffic, exhaustive sweep and async reset.
module tb_cla_adder_4bit;
  import cla_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  logic      in_valid = 1'b0;
  cla_word_t a = '0;
  cla_word_t b = '0;
  logic      cin = 1'b0;
  logic      out_valid;
  cla_word_t sum;
  logic      cout, grp_p, grp_g;
`ifdef CLA_ADDER_OVF_EN
  logic      ovf;
`else
  logic      ovf = 1'b0;
`endif

  int n_checks = 0;
  int n_fail = 0;

  cla_adder_4bit #(.OUT_REG(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .sum       (sum),
    .cout      (cout),
    .grp_p     (grp_p),
`ifdef CLA_ADDER_OVF_EN
    .ovf       (ovf),
`endif
    .grp_g     (grp_g)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the captured operands.
  logic      m_valid = 1'b0;
  cla_word_t m_sum = '0;
  logic      m_cout = 1'b0, m_gp = 1'b0, m_gg = 1'b0, m_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int total, sa, sb, st;
    if (!rst_n) begin
      m_valid = 1'b0; m_sum = '0; m_cout = 1'b0; m_gp = 1'b0; m_gg = 1'b0; m_ovf = 1'b0;
    end else begin
      m_valid = in_valid;
      if (in_valid) begin
        total  = int'(a) + int'(b) + int'(cin);
        m_sum  = cla_word_t'(total % 16);
        m_cout = (total > 15);
        m_gp   = ((a ^ b) == 4'hF);
        m_gg   = (int'(a) + int'(b) > 15);
        sa = (a > 7) ? int'(a) - 16 : int'(a);
        sb = (b > 7) ? int'(b) - 16 : int'(b);
        st = sa + sb + int'(cin);
        m_ovf  = (st > 7) || (st < -8);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("out_valid", out_valid, m_valid);
    chk("sum", sum, m_sum);
    chk("cout", cout, m_cout);
    chk("grp_p", grp_p, m_gp);
    chk("grp_g", grp_g, m_gg);
`ifdef CLA_ADDER_OVF_EN
    chk("ovf", ovf, m_ovf);
`endif
  end

  task automatic drive(input logic v, input logic [3:0] ta, input logic [3:0] tb_, input logic tc);
    @(negedge clk);
    in_valid = v; a = ta; b = tb_; cin = tc;
  endtask

  // Checks the result of the most recently driven vector, after its capture edge.
  task automatic lit(input string name, input int e_sum, input int e_cout, input int e_gp,
                     input int e_gg, input int e_ovf);
    @(posedge clk);
    #2;
    chk({name, ".valid"}, out_valid, 1);
    chk({name, ".sum"}, sum, e_sum);
    chk({name, ".cout"}, cout, e_cout);
    chk({name, ".grp_p"}, grp_p, e_gp);
    chk({name, ".grp_g"}, grp_g, e_gg);
`ifdef CLA_ADDER_OVF_EN
    chk({name, ".ovf"}, ovf, e_ovf);
`endif
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst.out_valid", out_valid, 0);
    chk("rst.sum", sum, 0);
    chk("rst.cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(1, 4'b0001, 4'b0010, 0); lit("v1", 3, 0, 0, 0, 0);
    drive(1, 4'b1010, 4'b0101, 0); lit("v2", 15, 0, 1, 0, 0);
    drive(1, 4'b1111, 4'b0001, 1); lit("v3", 1, 1, 0, 1, 0);
    drive(1, 4'b1100, 4'b1010, 0); lit("v4", 6, 1, 0, 1, 1);
    drive(0, 4'b0000, 4'b0000, 0);
    @(posedge clk); #2;
    chk("idle.out_valid", out_valid, 0);
    chk("idle.sum_hold", sum, 6);
    chk("idle.cout_hold", cout, 1);

    for (int i = 0; i < 200; i++)
      drive(($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 1'($urandom));

    for (int i = 0; i < 512; i++)
      drive(1, 4'(i), 4'(i >> 4), 1'(i >> 8));

    drive(1, 4'b0111, 4'b0111, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.out_valid", out_valid, 0);
    chk("arst.sum", sum, 0);
    chk("arst.cout", cout, 0);
    chk("arst.grp_p", grp_p, 0);
    chk("arst.grp_g", grp_g, 0);
`ifdef CLA_ADDER_OVF_EN
    chk("arst.ovf", ovf, 0);
`endif
    @(posedge clk); #2;
    chk("arst.discard", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; a = 4'b0110; b = 4'b0011; cin = 1'b1;
    lit("post_rst", 10, 0, 0, 0, 1);
    drive(0, 4'b0000, 4'b0000, 0);
    repeat (2) @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
